// File: rtl/mult_pipe.sv
// mult_pipe: elastic valid/ready pipelined multiplier carrying an opaque tag per op.
// Define MULT_SQUASH_EN to add the squash port that flushes all in-flight ops.
package mult_pkg;
    typedef enum logic [1:0] {M_MUL, M_MULH, M_MULHSU, M_MULHU} mult_func_e;
endpackage

module mult_pipe
    import mult_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  mult_func_e       func,
    input  logic [TAG_W-1:0] in_tag,
`ifdef MULT_SQUASH_EN
    input  logic             squash,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag
);
    localparam int W2 = 2 * XLEN;
    localparam int S  = W2 / STAGES;

    logic              flush;
    logic              full_above;
    logic [STAGES-1:0] v, adv, ld;
    logic [W2-1:0]     a_ext, b_ext;
    logic [W2-1:0]     sum_q [STAGES];
    logic [W2-1:0]     mpl_q [STAGES];
    logic [W2-1:0]     mcd_q [STAGES];
    mult_func_e        fn_q  [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];

`ifdef MULT_SQUASH_EN
    assign flush = squash;
`else
    assign flush = 1'b0;
`endif

    // A stage advances when the output drains or any later stage has a hole.
    always_comb begin
        a_ext = {{XLEN{rs1[XLEN-1] && func != M_MULHU}}, rs1};
        b_ext = {{XLEN{rs2[XLEN-1] && (func == M_MUL || func == M_MULH)}}, rs2};
        full_above = 1'b1;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = v[k] && (out_ready || !full_above);
            full_above = full_above && v[k];
        end
        in_ready = !flush && (!v[0] || adv[0]);
        ld[0] = in_valid && in_ready;
        for (int k = 1; k < STAGES; k++)
            ld[k] = adv[k-1];
    end

    always_ff @(posedge clock) begin
        if (reset || flush)
            v <= '0;
        else
            v <= ld | (v & ~adv);
    end

    // Data registers load only with their valid bit; empty stages keep stale data.
    always_ff @(posedge clock) begin
        if (ld[0]) begin
            sum_q[0] <= W2'(b_ext[S-1:0]) * a_ext;
            mpl_q[0] <= b_ext >> S;
            mcd_q[0] <= a_ext << S;
            fn_q[0]  <= func;
            tag_q[0] <= in_tag;
        end
        for (int k = 1; k < STAGES; k++)
            if (ld[k]) begin
                sum_q[k] <= sum_q[k-1] + W2'(mpl_q[k-1][S-1:0]) * mcd_q[k-1];
                mpl_q[k] <= mpl_q[k-1] >> S;
                mcd_q[k] <= mcd_q[k-1] << S;
                fn_q[k]  <= fn_q[k-1];
                tag_q[k] <= tag_q[k-1];
            end
    end

    assign out_valid = v[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign result    = fn_q[STAGES-1] == M_MUL ? sum_q[STAGES-1][XLEN-1:0]
                                               : sum_q[STAGES-1][W2-1:XLEN];
endmodule

// File: tb/tb_mult_pipe.sv
// tb_mult_pipe: directed and random checks of mult_pipe against a queue-based
// arithmetic reference model.
module tb_mult_pipe;
    import mult_pkg::*;
    localparam int XLEN = 32, STAGES = 4, TAG_W = 16;

    logic             clock = 0, reset = 1;
    logic             in_valid = 0, in_ready, out_valid, out_ready = 0, squash = 0;
    logic [XLEN-1:0]  rs1 = 0, rs2 = 0, result;
    mult_func_e       func = M_MUL;
    logic [TAG_W-1:0] in_tag = 0, out_tag;
    int               vectors = 0, miscompares = 0;

    typedef struct packed {
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] tag;
    } exp_t;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    mult_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .func(func), .in_tag(in_tag),
`ifdef MULT_SQUASH_EN
        .squash(squash),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag)
    );

    function automatic logic [XLEN-1:0] ref_mul(mult_func_e f, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] x, y, p;
        x = (f == M_MULHU) ? {{XLEN{1'b0}}, a} : {{XLEN{a[XLEN-1]}}, a};
        y = (f == M_MUL || f == M_MULH) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
        p = x * y;
        return (f == M_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    function automatic logic [XLEN-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic mult_func_e rnd_func();
        return mult_func_e'($urandom_range(0, 3));
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", name, got, want);
        end
    endtask

    // Leaves in_valid high; caller drops it or drives the next op.
    task automatic send(mult_func_e f, logic [XLEN-1:0] a, logic [XLEN-1:0] b, logic [TAG_W-1:0] t);
        in_valid = 1; func = f; rs1 = a; rs2 = b; in_tag = t;
        for (int n = 0; ; n++) begin
            @(negedge clock);
            if (in_ready) break;
            if (n == 50) begin
                check("send_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic expect_out(string name, logic [XLEN-1:0] res, logic [TAG_W-1:0] t);
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (out_valid) break;
        end
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_result"}, 64'(result), 64'(res));
        check({name, "_tag"}, 64'(out_tag), 64'(t));
        @(posedge clock); #1;
    endtask

    task automatic latency_check(string name, logic [XLEN-1:0] res, logic [TAG_W-1:0] t);
        for (int i = 1; i <= STAGES; i++) begin
            @(negedge clock);
            check({name, "_lat_valid"}, 64'(out_valid), 64'(i == STAGES));
        end
        check({name, "_result"}, 64'(result), 64'(res));
        check({name, "_tag"}, 64'(out_tag), 64'(t));
        @(posedge clock); #1;
    endtask

    // Scoreboard: any presented result must match the oldest outstanding op.
    always @(negedge clock) begin
        if (reset)
            exp_q.delete();
        else begin
            if (out_valid) begin
                if (exp_q.size() == 0)
                    check("spurious_out_valid", 64'd1, 64'd0);
                else begin
                    check("sb_result", 64'(result), 64'(exp_q[0].res));
                    check("sb_tag", 64'(out_tag), 64'(exp_q[0].tag));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (squash)
                exp_q.delete();
            else if (in_valid && in_ready)
                exp_q.push_back(exp_t'{res: ref_mul(func, rs1, rs2), tag: in_tag});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [XLEN-1:0] exp_a;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clock); #1;

        out_ready = 1;
        send(M_MUL, 32'd7, 32'd6, 16'h00AB);
        in_valid = 0;
        latency_check("mul", 32'd42, 16'h00AB);

        send(M_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h11);
        send(M_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h12);
        send(M_MULHSU, 32'hFFFF_FFFF, 32'd2,         16'h13);
        in_valid = 0;
        expect_out("mulh",   32'h0000_0000, 16'h11);
        expect_out("mulhu",  32'hFFFF_FFFE, 16'h12);
        expect_out("mulhsu", 32'hFFFF_FFFF, 16'h13);

        out_ready = 0;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1; func = rnd_func(); rs1 = rnd_op(); rs2 = rnd_op(); in_tag = 16'(i);
            @(negedge clock);
            check("bp_in_ready", 64'(in_ready), 64'(i <= STAGES));
            @(posedge clock); #1;
        end
        @(negedge clock);
        check("bp_hold_ready", 64'(in_ready), 64'd0);
        check("bp_hold_tag", 64'(out_tag), 64'd1);
        @(posedge clock); #1;
        out_ready = 1;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clock);
            check("drain_valid", 64'(out_valid), 64'd1);
            check("drain_tag", 64'(out_tag), 64'(j));
            if (j == 1) check("pass_through_ready", 64'(in_ready), 64'd1);
            @(posedge clock); #1;
            if (j == 1) begin
                func = rnd_func(); rs1 = rnd_op(); rs2 = rnd_op(); in_tag = 16'd6;
            end
            if (j == 2) in_valid = 0;
        end

        out_ready = 0;
        send(rnd_func(), rnd_op(), rnd_op(), 16'hA);
        exp_a = ref_mul(func, rs1, rs2);
        in_valid = 0;
        repeat (2) @(posedge clock);
        #1;
        send(rnd_func(), rnd_op(), rnd_op(), 16'hB);
        in_valid = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("bubble_hold_valid", 64'(out_valid), 64'd1);
            check("bubble_hold_tag", 64'(out_tag), 64'hA);
            check("bubble_hold_result", 64'(result), 64'(exp_a));
            @(posedge clock); #1;
        end
        out_ready = 1;
        @(negedge clock);
        check("bubble_a_tag", 64'(out_tag), 64'hA);
        @(posedge clock); #1;
        @(negedge clock);
        check("bubble_b_valid", 64'(out_valid), 64'd1);
        check("bubble_b_tag", 64'(out_tag), 64'hB);
        @(posedge clock); #1;

`ifdef MULT_SQUASH_EN
        for (int i = 0; i < 3; i++) send(rnd_func(), rnd_op(), rnd_op(), 16'(32'h20 + i));
        squash = 1; in_tag = 16'h2F;
        @(negedge clock);
        check("squash_in_ready", 64'(in_ready), 64'd0);
        check("squash_out_valid", 64'(out_valid), 64'd0);
        @(posedge clock); #1;
        squash = 0; in_valid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check("post_squash_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clock); #1;
        send(M_MUL, 32'd12345, 32'd1000, 16'h30);
        in_valid = 0;
        latency_check("post_squash", 32'd12345000, 16'h30);
`endif

        out_ready = 0;
        for (int i = 0; i < STAGES; i++) send(rnd_func(), rnd_op(), rnd_op(), 16'(32'h40 + i));
        in_valid = 0;
        @(posedge clock); #1;
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        @(negedge clock);
        check("rst_full_out_valid", 64'(out_valid), 64'd0);
        check("rst_full_in_ready", 64'(in_ready), 64'd1);
        @(posedge clock); #1;

        for (int c = 0; c < 400; c++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            func      = rnd_func();
            rs1       = rnd_op();
            rs2       = rnd_op();
            in_tag    = 16'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
`ifdef MULT_SQUASH_EN
            squash    = $urandom_range(0, 40) == 0;
`endif
            @(posedge clock); #1;
        end
        in_valid = 0; squash = 0; out_ready = 1;
        for (int c = 0; c < 3 * STAGES && exp_q.size() != 0; c++) @(posedge clock);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mult_pipe.md
# mult_pipe

Parametrised, elastic pipelined integer multiplier for the out-of-order core's execute stage. It replaces the fixed-depth, globally-stalled multiplier with a valid/ready pipeline of configurable operand width and stage count. Each stage advances independently, so bubbles collapse while the output is blocked. It carries an opaque tag (ROB index and destination PRN) alongside each operation and can flush all in-flight work on a mispredict squash.

## Interface
Parameters:
- XLEN, 32: operand and result width.
- STAGES, 4: pipeline depth. Must divide 2*XLEN; each stage consumes 2*XLEN/STAGES multiplier bits.
- TAG_W, 16: width of the opaque tag carried with each op (ROBN concatenated with PRN).

Ports:
- clock  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  stage 0 can accept this cycle.
- rs1, rs2  in  XLEN  operands.
- func  in  MULT_FUNC  M_MUL / M_MULH / M_MULHSU / M_MULHU.
- in_tag  in  TAG_W  passed through unmodified.
- squash  in  1  flush all in-flight ops (present only under MULT_SQUASH_EN).
- out_valid  out  1  result present in the final stage.
- out_ready  in  1  consumer (CDB arbiter) accepts this cycle.
- result  out  XLEN  selected product half.
- out_tag  out  TAG_W  tag of the op on result.

## Operation
- Sign extension to 2*XLEN at input:
  - rs1 signed for MUL, MULH, MULHSU.
  - rs2 signed for MUL and MULH.
  - All other cases zero-extend.
- Stage k, per op:
  - sum += mplier[S-1:0] * mcand, where S = 2*XLEN/STAGES.
  - mplier >>= S (logical); mcand <<= S.
  - func and tag are forwarded with the op.
- Product is taken mod 2^(2*XLEN).
- result is product[XLEN-1:0] for M_MUL, else product[2*XLEN-1:XLEN].
- Each stage holds a valid bit.
  - Stage k loads from stage k-1 when stage k is empty or advancing.
  - The final stage advances when out_valid && out_ready.
  - in_ready = !v[0] || stage 0 advancing. This is combinational and has no dependence on in_valid.
- Accept occurs when in_valid && in_ready.
- Data registers of empty stages may hold stale values. Only valid bits are reset.
- No reordering: results leave in acceptance order.

## Timing
- Reset: all valid bits 0; out_valid = 0; in_ready = 1 the cycle after reset deasserts.
  - result and out_tag are don't-care while out_valid = 0.
- Latency: an op accepted at edge N presents out_valid at cycle N+STAGES, provided it is not stalled.
- Throughput: one op per cycle while out_ready is held high.
- Backpressure: with out_ready low, the pipe fills to STAGES ops, then in_ready drops.
  - in_ready rises in the same cycle out_ready rises (pass-through).
  - result and out_tag stay stable while out_valid && !out_ready.
- Squash (under MULT_SQUASH_EN):
  - At the edge where squash = 1, all valid bits clear.
  - An in_valid in that same cycle is dropped. in_ready is forced to 0 while squash is high.
  - out_valid is 0 the following cycle.
  - An out handshake in the squash cycle still completes: the consumer sees it.
- Reset mid-operation: all ops are discarded, identical to squash.
- Reset has priority over squash.

## Configuration
- MULT_SQUASH_EN defined: the squash port and flush logic are present, with behaviour as above.
- MULT_SQUASH_EN undefined: there is no squash port. In-flight ops are cleared only by reset. The core must drain the unit or discard results by tag.

## Test plan
Run with XLEN=32 and STAGES=4.
- M_MUL, rs1=7, rs2=6, out_ready=1 -> out_valid exactly 4 cycles after accept; result=42; out_tag echoed.
- Signed/unsigned high halves:
  - M_MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000.
  - M_MULHU same operands -> 0xFFFFFFFE.
  - M_MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- 6 back-to-back ops, tags 1..6, out_ready=0:
  - in_ready drops after the 4th accept.
  - Raising out_ready drains tags 1..6 in order, one per cycle, with no gaps.
- Bubble collapse:
  - Accept op A, idle 2 cycles, accept op B, with out_ready=0.
  - Both reach adjacent stages; A is held stable on result.
  - B appears the cycle after A's handshake.
- Squash with 3 ops in flight and in_valid=1 in the squash cycle:
  - out_valid never asserts for any of them.
  - The next accepted op completes with correct latency.
- Reset asserted with the pipe full -> out_valid=0 and in_ready=1 on the first cycle after reset deasserts.
